line_follow_ctrl: RTL and testbench



---
 rtl/line_follow_pkg.sv | 51 +++++
 rtl/line_follow_ctrl_debounce.sv | 49 ++++
 rtl/line_follow_ctrl.sv | 155 +++++++++++++++
 tb/tb_line_follow_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Motion codes, steering FSM state type and sensor-pattern decode shared by line_follow_ctrl.
// The ST_REVERSE state exists only when LINE_FOLLOW_REVERSE_EN is defined.
package line_follow_pkg;

    localparam logic [2:0] STOP  = 3'b000;
    localparam logic [2:0] FWD   = 3'b010;
    localparam logic [2:0] LEFT  = 3'b110;
    localparam logic [2:0] RIGHT = 3'b100;
    localparam logic [2:0] SPIN  = 3'b101;
    localparam logic [2:0] REV   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FWD     = 3'd1,
        ST_LEFT    = 3'd2,
        ST_RIGHT   = 3'd3,
        ST_SEARCH  = 3'd4,
        ST_HALT    = 3'd5
`ifdef LINE_FOLLOW_REVERSE_EN
        , ST_REVERSE = 3'd6
`endif
    } state_t;

    // ST_IDLE doubles as "no line": IDLE is never a steering target.
    function automatic state_t decode_lcr(input logic [2:0] lcr);
        state_t st;
        case (lcr)
            3'b010, 3'b111, 3'b101: st = ST_FWD;
            3'b110, 3'b100:         st = ST_LEFT;
            3'b011, 3'b001:         st = ST_RIGHT;
            default:                st = ST_IDLE;
        endcase
        return st;
    endfunction

    function automatic logic [2:0] motion_code(input state_t st);
        logic [2:0] code;
        case (st)
            ST_FWD:     code = FWD;
            ST_LEFT:    code = LEFT;
            ST_RIGHT:   code = RIGHT;
            ST_SEARCH:  code = SPIN;
`ifdef LINE_FOLLOW_REVERSE_EN
            ST_REVERSE: code = REV;
`endif
            default:    code = STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/line_follow_ctrl_debounce.sv
// One IR sensor bit: 2-flop synchroniser followed by a stability-counter debouncer.
// The debounced bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower steering controller: debounced L/C/R sensors drive a dwell-limited FSM that
// emits the 3-bit motion code for the PWM stage. Define LINE_FOLLOW_REVERSE_EN to back up before searching.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int MIN_DWELL       = 240000,
    parameter int LOST_TIMEOUT    = 1200000,
    parameter int SEARCH_TIMEOUT  = 36000000
`ifdef LINE_FOLLOW_REVERSE_EN
    , parameter int REVERSE_CYCLES = 2400000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [2:0] sel,
    output logic       halted,
    output logic       line_seen,
    output state_t     state_dbg
);
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int LW = $clog2(LOST_TIMEOUT + 1);
    localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
`ifdef LINE_FOLLOW_REVERSE_EN
    localparam int RW = $clog2(REVERSE_CYCLES + 1);
`endif

    logic [2:0]    deb;
    state_t        state_q, state_d;
    state_t        dec;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [SW-1:0] search_q, search_d;
`ifdef LINE_FOLLOW_REVERSE_EN
    logic [RW-1:0] rev_q, rev_d;
`endif

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clk(clk), .rst_n(rst_n), .din(sensor[2]), .dout(deb[2]));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
        .clk(clk), .rst_n(rst_n), .din(sensor[1]), .dout(deb[1]));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk(clk), .rst_n(rst_n), .din(sensor[0]), .dout(deb[0]));

    assign dec = decode_lcr(deb);

    // Dwell is loaded with MIN_DWELL-1 on entry so steering changes are at least MIN_DWELL edges apart.
    always_comb begin
        state_d  = state_q;
        dwell_d  = (dwell_q != '0) ? dwell_q - DW'(1) : dwell_q;
        lost_d   = lost_q;
        search_d = search_q;
`ifdef LINE_FOLLOW_REVERSE_EN
        rev_d    = rev_q;
`endif
        if (!enable) begin
            state_d  = ST_IDLE;
            dwell_d  = '0;
            lost_d   = '0;
            search_d = '0;
`ifdef LINE_FOLLOW_REVERSE_EN
            rev_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FWD;
                    dwell_d = DW'(MIN_DWELL - 1);
                    lost_d  = '0;
                end
                ST_FWD, ST_LEFT, ST_RIGHT: begin
                    if (dec == ST_IDLE) begin
                        if (lost_q >= LW'(LOST_TIMEOUT - 1)) begin
                            lost_d   = '0;
                            search_d = '0;
`ifdef LINE_FOLLOW_REVERSE_EN
                            state_d  = ST_REVERSE;
                            rev_d    = '0;
`else
                            state_d  = ST_SEARCH;
`endif
                        end else begin
                            lost_d = lost_q + LW'(1);
                        end
                    end else begin
                        lost_d = '0;
                        if (dwell_q == '0 && dec != state_q) begin
                            state_d = dec;
                            dwell_d = DW'(MIN_DWELL - 1);
                        end
                    end
                end
`ifdef LINE_FOLLOW_REVERSE_EN
                ST_REVERSE: begin
                    if (dec != ST_IDLE) begin
                        state_d = dec;
                        dwell_d = DW'(MIN_DWELL - 1);
                        rev_d   = '0;
                    end else if (rev_q >= RW'(REVERSE_CYCLES - 1)) begin
                        state_d  = ST_SEARCH;
                        search_d = '0;
                        rev_d    = '0;
                    end else begin
                        rev_d = rev_q + RW'(1);
                    end
                end
`endif
                ST_SEARCH: begin
                    if (dec != ST_IDLE) begin
                        state_d  = dec;
                        dwell_d  = DW'(MIN_DWELL - 1);
                        lost_d   = '0;
                        search_d = '0;
                    end else if (search_q >= SW'(SEARCH_TIMEOUT - 1)) begin
                        state_d  = ST_HALT;
                        search_d = '0;
                    end else begin
                        search_d = search_q + SW'(1);
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            lost_q   <= '0;
            search_q <= '0;
`ifdef LINE_FOLLOW_REVERSE_EN
            rev_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            lost_q   <= lost_d;
            search_q <= search_d;
`ifdef LINE_FOLLOW_REVERSE_EN
            rev_q    <= rev_d;
`endif
        end
    end

    // Outputs decode the registered state, so sel moves on the same edge as the state.
    assign sel       = motion_code(state_q);
    assign halted    = (state_q == ST_HALT);
    assign line_seen = |deb;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl: stimulus pushes expected sel transitions and status
// snapshots (with their cycle numbers) into queues; a negedge monitor pops and compares them.
module tb_line_follow_ctrl;
    import line_follow_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] sensor;
    logic [2:0] sel;
    logic       halted;
    logic       line_seen;
    state_t     state_dbg;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;
    bit mon_en = 1'b0;
    logic [2:0] prev_sel;

    // {cycle[31:0], sel[2:0]}
    logic [34:0] exp_q[$];
    // {cycle[31:0], sel[2:0], halted, line_seen}
    logic [36:0] chk_q[$];

    line_follow_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .MIN_DWELL(8),
        .LOST_TIMEOUT(16),
        .SEARCH_TIMEOUT(32)
`ifdef LINE_FOLLOW_REVERSE_EN
        , .REVERSE_CYCLES(6)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .sensor(sensor),
        .sel(sel),
        .halted(halted),
        .line_seen(line_seen),
        .state_dbg(state_dbg)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_sel(input int at, input logic [2:0] v);
        exp_q.push_back({32'(at), v});
    endtask

    task automatic exp_stat(input int at, input logic [2:0] v, input logic h, input logic ls);
        chk_q.push_back({32'(at), v, h, ls});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [34:0] e;
        logic [36:0] s;
        if (!mon_en) begin
            prev_sel = sel;
        end else if (sel !== prev_sel) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL sel_change: got sel=%b at cycle %0d, no change expected", sel, cyc);
            end else begin
                e = exp_q.pop_front();
                if (sel !== e[2:0] || cyc != int'(e[34:3])) begin
                    n_miss++;
                    $display("FAIL sel_change: got sel=%b at cycle %0d, expected sel=%b at cycle %0d",
                             sel, cyc, e[2:0], int'(e[34:3]));
                end
            end
            prev_sel = sel;
        end
        while (chk_q.size() != 0 && int'(chk_q[0][36:5]) < cyc) begin
            s = chk_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL status: snapshot for cycle %0d not sampled", int'(s[36:5]));
        end
        if (chk_q.size() != 0 && int'(chk_q[0][36:5]) == cyc) begin
            s = chk_q.pop_front();
            n_vec++;
            if ({sel, halted, line_seen} !== s[4:0]) begin
                n_miss++;
                $display("FAIL status@%0d: got sel=%b halted=%b line_seen=%b, expected sel=%b halted=%b line_seen=%b",
                         cyc, sel, halted, line_seen, s[4:2], s[1], s[0]);
            end
        end
    end

    // stimulus: DEBOUNCE=4 so a raw change made after edge N lands in the debounced value at N+6
    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        sensor = 3'b010;

        // reset, then release with enable high
        goto_cyc(3);
        exp_stat(3, STOP, 1'b0, 1'b0);
        exp_sel(4, FWD);
        exp_stat(4, FWD, 1'b0, 1'b0);
        exp_stat(8, FWD, 1'b0, 1'b0);
        exp_stat(9, FWD, 1'b0, 1'b1);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // 3-cycle glitch must not propagate
        goto_cyc(20);
        sensor = 3'b110;
        goto_cyc(23);
        sensor = 3'b010;
        exp_stat(28, FWD, 1'b0, 1'b1);

        // held change: sel follows 2+4+1 cycles later
        goto_cyc(30);
        sensor = 3'b110;
        exp_sel(37, LEFT);

        // change right at LEFT entry: debounce alone would allow 44, dwell holds it to 45
        goto_cyc(37);
        sensor = 3'b011;
        exp_sel(45, RIGHT);

        // line lost -> search, then found again
        goto_cyc(60);
        sensor = 3'b000;
        exp_stat(70, RIGHT, 1'b0, 1'b0);
`ifdef LINE_FOLLOW_REVERSE_EN
        exp_sel(82, REV);
        exp_sel(88, SPIN);
`else
        exp_sel(82, SPIN);
`endif
        goto_cyc(90);
        sensor = 3'b010;
        exp_sel(97, FWD);

        // lost for good -> halt after the search window
        goto_cyc(110);
        sensor = 3'b000;
`ifdef LINE_FOLLOW_REVERSE_EN
        exp_sel(132, REV);
        exp_sel(138, SPIN);
        exp_sel(170, STOP);
        exp_stat(172, STOP, 1'b1, 1'b0);
`else
        exp_sel(132, SPIN);
        exp_sel(164, STOP);
        exp_stat(166, STOP, 1'b1, 1'b0);
`endif
        goto_cyc(180);
        enable = 1'b0;
        exp_stat(181, STOP, 1'b0, 1'b0);
        goto_cyc(183);
        enable = 1'b1;
        sensor = 3'b010;
        exp_sel(184, FWD);

        // abort during search
        goto_cyc(200);
        sensor = 3'b000;
`ifdef LINE_FOLLOW_REVERSE_EN
        exp_sel(222, REV);
        exp_sel(228, SPIN);
`else
        exp_sel(222, SPIN);
`endif
        goto_cyc(230);
        enable = 1'b0;
        exp_sel(231, STOP);

        // re-enable into LEFT; dwell from FWD entry at 234 holds the turn to 242
        goto_cyc(233);
        enable = 1'b1;
        sensor = 3'b110;
        exp_sel(234, FWD);
        exp_sel(242, LEFT);

        // one-cycle reset mid-LEFT; debouncers restart from 000
        goto_cyc(250);
        rst_n  = 1'b0;
        enable = 1'b0;
        exp_sel(251, STOP);
        exp_stat(251, STOP, 1'b0, 1'b0);
        goto_cyc(251);
        rst_n = 1'b1;
        exp_stat(255, STOP, 1'b0, 1'b0);
        exp_stat(258, STOP, 1'b0, 1'b1);

        goto_cyc(270);

        // final report
        while (exp_q.size() != 0) begin
            logic [34:0] e;
            e = exp_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL sel_change: expected sel=%b at cycle %0d never seen", e[2:0], int'(e[34:3]));
        end
        while (chk_q.size() != 0) begin
            logic [36:0] s;
            s = chk_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL status: snapshot for cycle %0d never sampled", int'(s[36:5]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
